// File: rtl/red_pitaya_daisy_test_rx.sv
// Receive-side checker for the daisy-chain link test pattern (counter or PRBS-16).
// Acquires lock on the incoming sequence, then counts matched/mismatched words and lock losses.
module red_pitaya_daisy_test_rx #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 8
) (
  input  logic        par_clk_i,
  input  logic        par_rstn_i,
  input  logic        par_dv_i,
  input  logic [15:0] par_dat_i,
  input  logic        en_i,
  input  logic        mode_i,
  input  logic        clr_i,
  output logic        locked_o,
  output logic        err_o,
  output logic [31:0] ok_cnt_o,
  output logic [31:0] err_cnt_o,
  output logic [15:0] lost_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEK   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [15:0] LOCK_V = 16'(LOCK_CNT);
  localparam logic [15:0] LOSS_V = 16'(LOSS_CNT);

  state_t      state_q, state_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] match_q, match_d;
  logic [15:0] miss_q, miss_d;
  logic        mode_q;
  logic        locked_q, locked_d;
  logic        err_q, err_d;
  logic [31:0] ok_q, ok_d;
  logic [31:0] errc_q, errc_d;
  logic [15:0] lost_q, lost_d;

  logic        hit;
  logic        mode_chg;
  logic [15:0] nxt_dat;
  logic [15:0] nxt_exp;

  function automatic logic [15:0] pat_next(input logic prbs, input logic [15:0] x);
    if (prbs)
      return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    else
      return x + 16'd1;
  endfunction

  assign hit      = (par_dat_i == exp_q);
  assign mode_chg = (mode_i != mode_q);
  assign nxt_dat  = pat_next(mode_q, par_dat_i);
  assign nxt_exp  = pat_next(mode_q, exp_q);

  always_ff @(posedge par_clk_i or negedge par_rstn_i) begin
    if (!par_rstn_i) begin
      state_q  <= IDLE;
      exp_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      mode_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      ok_q     <= '0;
      errc_q   <= '0;
      lost_q   <= '0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      mode_q   <= mode_i;
      locked_q <= locked_d;
      err_q    <= err_d;
      ok_q     <= ok_d;
      errc_q   <= errc_d;
      lost_q   <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    ok_d    = ok_q;
    errc_d  = errc_q;
    lost_d  = lost_q;

    if (!en_i) begin
      state_d = IDLE;
      match_d = '0;
      miss_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SEEK;
        end

        SEEK: begin
          if (mode_chg) begin
            match_d = '0;
          end else if (par_dv_i) begin
            exp_d = nxt_dat;
            if (match_q != '0 && hit) begin
              match_d = match_q + 16'd1;
              if (match_q + 16'd1 == LOCK_V) begin
                state_d = LOCKED;
                miss_d  = '0;
              end
            end else if (mode_q && par_dat_i == '0) begin
              // all-zero is the PRBS lock-up state and must never seed
              match_d = '0;
            end else begin
              match_d = 16'd1;
              if (LOCK_V <= 16'd1) begin
                state_d = LOCKED;
                miss_d  = '0;
              end
            end
          end
        end

        LOCKED: begin
          if (mode_chg) begin
            state_d = SEEK;
            match_d = '0;
            miss_d  = '0;
          end else if (par_dv_i) begin
            // free-running expectation: errors never resync the generator
            exp_d = nxt_exp;
            if (hit) begin
              ok_d   = (ok_q == '1) ? ok_q : ok_q + 32'd1;
              miss_d = '0;
            end else begin
              errc_d = (errc_q == '1) ? errc_q : errc_q + 32'd1;
              err_d  = 1'b1;
              if (miss_q + 16'd1 == LOSS_V) begin
                state_d = SEEK;
                lost_d  = (lost_q == '1) ? lost_q : lost_q + 16'd1;
                match_d = '0;
                miss_d  = '0;
              end else begin
                miss_d = miss_q + 16'd1;
              end
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (clr_i) begin
      ok_d   = '0;
      errc_d = '0;
      lost_d = '0;
    end
  end

  assign locked_d = (state_d == LOCKED);

  assign locked_o   = locked_q;
  assign err_o      = err_q;
  assign ok_cnt_o   = ok_q;
  assign err_cnt_o  = errc_q;
  assign lost_cnt_o = lost_q;

endmodule

// File: tb/tb_red_pitaya_daisy_test_rx.sv
// Bench for red_pitaya_daisy_test_rx: directed link scenarios followed by randomized
// traffic, every cycle compared against a behavioural reference of the checker.
module tb_red_pitaya_daisy_test_rx;

  localparam int LOCK = 4;
  localparam int LOSS = 8;

  logic        par_clk_i;
  logic        par_rstn_i;
  logic        par_dv_i;
  logic [15:0] par_dat_i;
  logic        en_i;
  logic        mode_i;
  logic        clr_i;
  logic        locked_o;
  logic        err_o;
  logic [31:0] ok_cnt_o;
  logic [31:0] err_cnt_o;
  logic [15:0] lost_cnt_o;

  int checks   = 0;
  int failures = 0;

  // reference state: 0 idle, 1 seeking, 2 locked
  int     m_st;
  int     m_exp;
  int     m_mr;
  int     m_miss;
  bit     m_mode;
  bit     m_erro;
  longint m_ok;
  longint m_err;
  longint m_lost;

  red_pitaya_daisy_test_rx #(
    .LOCK_CNT(LOCK),
    .LOSS_CNT(LOSS)
  ) dut (
    .par_clk_i (par_clk_i),
    .par_rstn_i(par_rstn_i),
    .par_dv_i  (par_dv_i),
    .par_dat_i (par_dat_i),
    .en_i      (en_i),
    .mode_i    (mode_i),
    .clr_i     (clr_i),
    .locked_o  (locked_o),
    .err_o     (err_o),
    .ok_cnt_o  (ok_cnt_o),
    .err_cnt_o (err_cnt_o),
    .lost_cnt_o(lost_cnt_o)
  );

  initial par_clk_i = 1'b0;
  always #5 par_clk_i = ~par_clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int nxt(input bit prbs, input int x);
    if (prbs)
      return ((x * 2) % 65536) + (((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1);
    else
      return (x + 1) % 65536;
  endfunction

  task automatic model_reset();
    m_st = 0; m_exp = 0; m_mr = 0; m_miss = 0; m_mode = 0; m_erro = 0;
    m_ok = 0; m_err = 0; m_lost = 0;
  endtask

  task automatic model_step(input bit en, input bit mode, input bit clr,
                            input bit dv, input int dat);
    m_erro = 0;
    if (!en) begin
      m_st = 0; m_mr = 0; m_miss = 0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (mode != m_mode) begin
      m_st = 1; m_mr = 0; m_miss = 0;
    end else if (dv && m_st == 1) begin
      if (m_mr > 0 && dat == m_exp) begin
        m_mr++;
        if (m_mr == LOCK) begin m_st = 2; m_miss = 0; end
      end else begin
        m_mr = (m_mode && dat == 0) ? 0 : 1;
      end
      m_exp = nxt(m_mode, dat);
    end else if (dv && m_st == 2) begin
      if (dat == m_exp) begin
        if (m_ok < 64'hFFFF_FFFF) m_ok++;
        m_miss = 0;
      end else begin
        if (m_err < 64'hFFFF_FFFF) m_err++;
        m_erro = 1;
        m_miss++;
        if (m_miss == LOSS) begin
          m_st = 1; m_mr = 0; m_miss = 0;
          if (m_lost < 64'hFFFF) m_lost++;
        end
      end
      m_exp = nxt(m_mode, m_exp);
    end
    m_mode = mode;
    if (clr) begin m_ok = 0; m_err = 0; m_lost = 0; end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".locked"}, 32'(locked_o), 32'(m_st == 2));
    chk({tag, ".err_o"},  32'(err_o),    32'(m_erro));
    chk({tag, ".ok"},     ok_cnt_o,      32'(m_ok));
    chk({tag, ".err"},    err_cnt_o,     32'(m_err));
    chk({tag, ".lost"},   32'(lost_cnt_o), 32'(m_lost));
  endtask

  task automatic cyc(input string tag, input bit en, input bit mode, input bit clr,
                     input bit dv, input int dat);
    en_i = en; mode_i = mode; clr_i = clr; par_dv_i = dv; par_dat_i = 16'(dat);
    @(posedge par_clk_i);
    model_step(en, mode, clr, dv, dat);
    #1;
    chk_all(tag);
  endtask

  int w;
  bit r_en, r_mode, r_clr, r_dv;
  int r_dat;

  initial begin
    par_rstn_i = 1'b0; par_dv_i = 1'b0; par_dat_i = '0;
    en_i = 1'b0; mode_i = 1'b0; clr_i = 1'b0;
    model_reset();
    repeat (2) @(posedge par_clk_i);
    #1;
    chk_all("reset");
    par_rstn_i = 1'b1;

    // counter lock on 0x0010..0x0013, then four good words
    cyc("enter_seek", 1, 0, 0, 0, 0);
    for (int i = 'h10; i <= 'h13; i++) cyc("cnt_lock", 1, 0, 0, 1, i);
    chk("locked_after_13", 32'(locked_o), 32'd1);
    for (int i = 'h14; i <= 'h17; i++) cyc("cnt_ok", 1, 0, 0, 1, i);
    chk("ok_after_17", ok_cnt_o, 32'd4);
    chk("err_after_17", err_cnt_o, 32'd0);

    // single corrupted word, with a data-valid gap in between
    cyc("bad_word", 1, 0, 0, 1, 'h1234);
    chk("err_pulse", 32'(err_o), 32'd1);
    cyc("gap", 1, 0, 0, 0, 'h5555);
    chk("err_pulse_single", 32'(err_o), 32'd0);
    cyc("good_19", 1, 0, 0, 1, 'h19);
    chk("err_cnt_one", err_cnt_o, 32'd1);
    chk("ok_cnt_five", ok_cnt_o, 32'd5);
    chk("still_locked", 32'(locked_o), 32'd1);

    // eight zero words lose lock, then relock on a fresh counter run
    for (int i = 0; i < 8; i++) cyc("zeros", 1, 0, 0, 1, 0);
    chk("lost_lock", 32'(locked_o), 32'd0);
    chk("lost_cnt_one", 32'(lost_cnt_o), 32'd1);
    for (int i = 'h100; i <= 'h103; i++) cyc("relock", 1, 0, 0, 1, i);
    chk("relocked", 32'(locked_o), 32'd1);

    // wrap-around sequence from a cleared, freshly enabled checker
    cyc("disable", 0, 0, 0, 1, 'h104);
    chk("idle_unlocked", 32'(locked_o), 32'd0);
    cyc("enable_clr", 1, 0, 1, 0, 0);
    w = 'hFFFE;
    for (int i = 0; i < 4; i++) begin
      cyc("wrap", 1, 0, 0, 1, w);
      w = (w + 1) % 65536;
    end
    chk("wrap_locked", 32'(locked_o), 32'd1);
    chk("wrap_err0", err_cnt_o, 32'd0);

    // PRBS: a mode switch forces reacquisition; zeros never seed
    cyc("mode_prbs", 1, 1, 0, 0, 0);
    chk("mode_unlock", 32'(locked_o), 32'd0);
    for (int i = 0; i < 4; i++) cyc("prbs_zero", 1, 1, 0, 1, 0);
    chk("zero_no_lock", 32'(locked_o), 32'd0);
    w = 'hACE1;
    for (int i = 0; i < 4; i++) begin
      cyc("prbs_lock", 1, 1, 0, 1, w);
      w = nxt(1, w);
    end
    chk("prbs_locked", 32'(locked_o), 32'd1);
    cyc("prbs_ok", 1, 1, 0, 1, w);
    chk("prbs_ok_cnt", ok_cnt_o, 32'd1);

    // clear coincident with a mismatch wins over the increment
    cyc("clr_vs_err", 1, 1, 1, 1, m_exp ^ 'h00FF);
    chk("clr_err_zero", err_cnt_o, 32'd0);
    chk("clr_err_pulse", 32'(err_o), 32'd1);

    // randomized traffic against the reference
    r_en = 1; r_mode = 1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(63) == 0) r_mode = ~r_mode;
      r_en  = ($urandom_range(79) != 0);
      r_clr = ($urandom_range(59) == 0);
      r_dv  = ($urandom_range(3) != 0);
      if ((m_st == 2 && $urandom_range(9) != 0) ||
          (m_st == 1 && m_mr > 0 && $urandom_range(7) != 0))
        r_dat = m_exp;
      else if ($urandom_range(15) == 0)
        r_dat = 0;
      else
        r_dat = int'($urandom_range(65535));
      cyc("rand", r_en, r_mode, r_clr, r_dv, r_dat);
    end

    // asynchronous reset while locked
    cyc("pre_rst_en", 1, 0, 0, 0, 0);
    cyc("pre_rst_seek", 1, 0, 0, 0, 0);
    w = 'h4000;
    for (int i = 0; i < 4; i++) begin
      cyc("pre_rst_lock", 1, 0, 0, 1, w);
      w = w + 1;
    end
    cyc("pre_rst_ok", 1, 0, 0, 1, w);
    chk("pre_rst_locked", 32'(locked_o), 32'd1);
    #2;
    par_rstn_i = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    chk("async_rst_ok", ok_cnt_o, 32'd0);
    @(posedge par_clk_i);
    #1;
    par_rstn_i = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
